// File: rtl/stopwatch_bcd_if.sv
// Command/status bundle between the stopwatch and its surrounding control logic.
// The master drives the tick and commands; the stopwatch (slave) returns BCD digits and status.
interface stopwatch_bcd_if;
  logic       tick_in;
  logic       start_stop;
  logic       clear;
  logic       timer_rearm;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       rollover;

  modport master (
    output tick_in, start_stop, clear,
    input  timer_rearm, sec_ones, sec_tens, min_ones, min_tens, running, rollover
  );

  modport slave (
    input  tick_in, start_stop, clear,
    output timer_rearm, sec_ones, sec_tens, min_ones, min_tens, running, rollover
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD mm:ss stopwatch advanced by rising edges of an upstream one-second level.
// Wraps from MIN_LIMIT:59 to 00:00 and keeps counting.
//
//   state | meaning
//   IDLE  | count held at 00:00, waiting for start_stop
//   RUN   | accepted ticks advance the count
//   PAUSE | count frozen, ticks ignored
module stopwatch_bcd #(
  parameter int MIN_LIMIT = 59
) (
  input  logic            clk,
  input  logic            reset_n,
  stopwatch_bcd_if.slave  sw
);

  localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t     state_q, state_d;
  logic       tick_in_q;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       running_q, running_d;
  logic       rollover_q, rollover_d;
  logic       timer_rearm_q, timer_rearm_d;
  logic       tick_acc;
  logic       at_limit;
  logic       zero_cnt;

  // Edge detect: a level held high for many cycles is one tick.
  assign tick_acc = sw.tick_in & ~tick_in_q;
  assign at_limit = (min_tens_q == LIM_TENS) && (min_ones_q == LIM_ONES) &&
                    (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tick_in_q     <= 1'b0;
      sec_ones_q    <= 4'd0;
      sec_tens_q    <= 4'd0;
      min_ones_q    <= 4'd0;
      min_tens_q    <= 4'd0;
      running_q     <= 1'b0;
      rollover_q    <= 1'b0;
      timer_rearm_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_in_q     <= sw.tick_in;
      sec_ones_q    <= sec_ones_d;
      sec_tens_q    <= sec_tens_d;
      min_ones_q    <= min_ones_d;
      min_tens_q    <= min_tens_d;
      running_q     <= running_d;
      rollover_q    <= rollover_d;
      timer_rearm_q <= timer_rearm_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sec_ones_d    = sec_ones_q;
    sec_tens_d    = sec_tens_q;
    min_ones_d    = min_ones_q;
    min_tens_d    = min_tens_q;
    rollover_d    = 1'b0;
    timer_rearm_d = 1'b0;
    zero_cnt      = 1'b0;

    unique case (state_q)
      IDLE: begin
        zero_cnt = 1'b1;
        if (!sw.clear && sw.start_stop) begin
          state_d       = RUN;
          timer_rearm_d = 1'b1;
        end
      end
      RUN: begin
        if (sw.clear) begin
          state_d  = IDLE;
          zero_cnt = 1'b1;
        end else begin
          if (tick_acc) begin
            timer_rearm_d = 1'b1;
            if (at_limit) begin
              zero_cnt   = 1'b1;
              rollover_d = 1'b1;
            end else if (sec_ones_q != 4'd9) begin
              sec_ones_d = sec_ones_q + 4'd1;
            end else begin
              sec_ones_d = 4'd0;
              if (sec_tens_q != 4'd5) begin
                sec_tens_d = sec_tens_q + 4'd1;
              end else begin
                sec_tens_d = 4'd0;
                if (min_ones_q != 4'd9) begin
                  min_ones_d = min_ones_q + 4'd1;
                end else begin
                  min_ones_d = 4'd0;
                  min_tens_d = min_tens_q + 4'd1;
                end
              end
            end
          end
          if (sw.start_stop) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (sw.clear) begin
          state_d  = IDLE;
          zero_cnt = 1'b1;
        end else if (sw.start_stop) begin
          state_d       = RUN;
          timer_rearm_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        zero_cnt = 1'b1;
      end
    endcase

    if (zero_cnt) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end
    running_d = (state_d == RUN);
  end

  assign sw.sec_ones    = sec_ones_q;
  assign sw.sec_tens    = sec_tens_q;
  assign sw.min_ones    = min_ones_q;
  assign sw.min_tens    = min_tens_q;
  assign sw.running     = running_q;
  assign sw.rollover    = rollover_q;
  assign sw.timer_rearm = timer_rearm_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench: two stopwatches (MIN_LIMIT 59 and 2) share one stimulus stream;
// every timer_rearm pulse pops one expected {running, rollover, mm:ss} word per DUT.
`timescale 1ns/1ps
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  int   rearm1 = 0;
  int   rearm2 = 0;
  int   n = 0;

  logic [17:0] q1[$];
  logic [17:0] q2[$];
  logic [17:0] e1, e2;

  stopwatch_bcd_if sw1();
  stopwatch_bcd_if sw2();

  assign sw2.tick_in    = sw1.tick_in;
  assign sw2.start_stop = sw1.start_stop;
  assign sw2.clear      = sw1.clear;

  stopwatch_bcd #(.MIN_LIMIT(59)) dut1 (.clk(clk), .reset_n(reset_n), .sw(sw1.slave));
  stopwatch_bcd #(.MIN_LIMIT(2))  dut2 (.clk(clk), .reset_n(reset_n), .sw(sw2.slave));

  always #5 clk = ~clk;

  wire [15:0] d1 = {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones};
  wire [15:0] d2 = {sw2.min_tens, sw2.min_ones, sw2.sec_tens, sw2.sec_ones};

  function automatic logic [17:0] exp_word(int cnt, int lim, bit run, bit roll);
    int m, mins, secs;
    m    = cnt % ((lim + 1) * 60);
    mins = m / 60;
    secs = m % 60;
    return {run, roll, 4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10)};
  endfunction

  // Expected response for the next rearm pulse; tk advances the model count.
  task automatic push(input bit run, input bit tk);
    if (tk) n++;
    q1.push_back(exp_word(n, 59, run, tk && (n % 3600 == 0)));
    q2.push_back(exp_word(n, 2, run, tk && (n % 180 == 0)));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end at posedge+1.
  task automatic pulse(input bit ss, input bit clr, input bit tk);
    sw1.start_stop = ss;
    sw1.clear      = clr;
    sw1.tick_in    = tk;
    @(posedge clk); #1;
    sw1.start_stop = 1'b0;
    sw1.clear      = 1'b0;
    sw1.tick_in    = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int hold);
    sw1.tick_in = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    sw1.tick_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (sw1.rollover && !sw1.timer_rearm) begin
        failures++;
        $display("FAIL roll_without_rearm1: rollover=1 timer_rearm=0");
      end
      if (sw1.timer_rearm) begin
        rearm1++;
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rearm1: got {run,roll,mmss}=%h with nothing expected", {sw1.running, sw1.rollover, d1});
        end else begin
          e1 = q1.pop_front();
          if ({sw1.running, sw1.rollover, d1} !== e1) begin
            failures++;
            $display("FAIL sb1: got {run,roll,mmss}=%h expected %h", {sw1.running, sw1.rollover, d1}, e1);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (sw2.rollover && !sw2.timer_rearm) begin
        failures++;
        $display("FAIL roll_without_rearm2: rollover=1 timer_rearm=0");
      end
      if (sw2.timer_rearm) begin
        rearm2++;
        checks++;
        if (q2.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rearm2: got {run,roll,mmss}=%h with nothing expected", {sw2.running, sw2.rollover, d2});
        end else begin
          e2 = q2.pop_front();
          if ({sw2.running, sw2.rollover, d2} !== e2) begin
            failures++;
            $display("FAIL sb2: got {run,roll,mmss}=%h expected %h", {sw2.running, sw2.rollover, d2}, e2);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    sw1.tick_in    = 1'b0;
    sw1.start_stop = 1'b0;
    sw1.clear      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_digits1", 32'(d1), 32'h0000);
    chk("reset_digits2", 32'(d2), 32'h0000);
    chk("reset_status1", 32'({sw1.running, sw1.rollover, sw1.timer_rearm}), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Start, then 12 ticks spaced apart.
    push(1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      push(1'b1, 1'b1);
      tick(1);
    end
    chk("twelve_ticks", 32'(d1), 32'h0012);
    chk("running_after_12", 32'(sw1.running), 32'h1);
    chk("rearm_count_13", 32'(rearm1), 32'd13);

    for (int i = 0; i < 47; i++) begin
      push(1'b1, 1'b1);
      tick(1);
    end
    chk("at_00_59", 32'(d1), 32'h0059);
    push(1'b1, 1'b1);
    tick(1);
    chk("carry_01_00", 32'(d1), 32'h0100);
    chk("no_rollover_01_00", 32'(sw1.rollover), 32'h0);

    for (int i = 0; i < 119; i++) begin
      push(1'b1, 1'b1);
      tick(1);
    end
    chk("lim2_at_02_59", 32'(d2), 32'h0259);
    push(1'b1, 1'b1);
    tick(1);
    chk("lim2_wrap", 32'(d2), 32'h0000);
    chk("lim2_roll_one_cycle", 32'(sw2.rollover), 32'h0);
    chk("lim59_03_00", 32'(d1), 32'h0300);
    push(1'b1, 1'b1);
    tick(1);
    chk("lim2_after_wrap", 32'(d2), 32'h0001);

    // Long high level counts once; then pause ignores ticks.
    push(1'b1, 1'b1);
    tick(40);
    chk("held_tick", 32'(d1), 32'h0302);
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1);
    chk("paused_count", 32'(d1), 32'h0302);
    chk("paused_running", 32'(sw1.running), 32'h0);

    // Resume; start_stop with a tick in RUN increments then pauses.
    push(1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b1);
    chk("ss_tick_run", 32'(d1), 32'h0303);
    chk("ss_tick_paused", 32'(sw1.running), 32'h0);
    push(1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // clear + start_stop + tick together.
    pulse(1'b1, 1'b1, 1'b1);
    n = 0;
    chk("clear_all_digits1", 32'(d1), 32'h0000);
    chk("clear_all_digits2", 32'(d2), 32'h0000);
    chk("clear_all_status", 32'({sw1.running, sw1.rollover}), 32'h0);

    // Count a little, then reset between clock edges.
    push(1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b1);
      tick(1);
    end
    chk("before_reset", 32'(d1), 32'h0003);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_digits", 32'(d1), 32'h0000);
    chk("async_reset_status", 32'({sw1.running, sw1.rollover, sw1.timer_rearm}), 32'h0);
    n = 0;
    sw1.tick_in = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sw1.tick_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tick(1);
    tick(1);
    chk("idle_after_reset", 32'(d1), 32'h0000);
    chk("idle_not_running", 32'(sw1.running), 32'h0);
    push(1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    push(1'b1, 1'b1);
    tick(1);
    chk("count_after_restart", 32'(d1), 32'h0001);

    chk("queue1_drained", 32'(q1.size()), 32'd0);
    chk("queue2_drained", 32'(q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter: MIN_LIMIT, default 59, maximum minutes value before wrap (legal range 1..99).
REQ-002 Port: clk  input  1  system clock, 50 MHz.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: tick_in  input  1  one-second timeout level from the upstream timer; only its rising edge is significant.
REQ-005 Port: start_stop  input  1  synchronous one-cycle command pulse that toggles run/pause.
REQ-006 Port: clear  input  1  synchronous one-cycle command pulse that zeroes the count and returns to IDLE.
REQ-007 Port: timer_rearm  output  1  one-cycle pulse requesting the upstream timer to restart its one-second count.
REQ-008 Port: sec_ones  output  4  BCD seconds units, 0..9.
REQ-009 Port: sec_tens  output  4  BCD seconds tens, 0..5.
REQ-010 Port: min_ones  output  4  BCD minutes units, 0..9.
REQ-011 Port: min_tens  output  4  BCD minutes tens, 0..9.
REQ-012 Port: running  output  1  high while in RUN.
REQ-013 Port: rollover  output  1  one-cycle pulse when the count wraps from MIN_LIMIT:59 to 00:00.

Function
REQ-014 tick_in SHALL be registered into tick_d; an accepted tick SHALL be tick_in & ~tick_d, evaluated in the same cycle.
REQ-015 A tick_in held high for N cycles SHALL produce exactly one accepted tick.
REQ-016 The FSM SHALL have three states, IDLE, RUN and PAUSE, with IDLE as the reset state.
REQ-017 In IDLE, start_stop SHALL move to RUN, clear SHALL hold IDLE, and the digits SHALL read 00:00.
REQ-018 In RUN, start_stop SHALL move to PAUSE and clear SHALL move to IDLE with the digits zeroed.
REQ-019 In PAUSE, start_stop SHALL move to RUN, clear SHALL move to IDLE with the digits zeroed, and accepted ticks SHALL be ignored.
REQ-020 clear SHALL have priority over start_stop when both are asserted in the same cycle.
REQ-021 Increments SHALL occur only when the current-state register equals RUN in the cycle of an accepted tick.
  - start_stop and tick in the same RUN cycle: increment applied, then the FSM enters PAUSE.
  - start_stop and tick in the same IDLE or PAUSE cycle: no increment.
REQ-022 clear and an accepted tick in the same cycle SHALL give 00:00 with no increment.
REQ-023 Latency: the digits SHALL show the new value on the first clock edge after the cycle in which the tick is accepted.
REQ-024 Digit carry SHALL follow this chain:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into the minutes.
  - The minutes are a two-digit BCD value.
  - Minutes equal to MIN_LIMIT with seconds 59 SHALL wrap to 00:00.
REQ-025 rollover SHALL assert for exactly the one cycle in which 00:00 first appears after a wrap, and counting SHALL continue in RUN.
REQ-026 timer_rearm SHALL assert for one cycle, registered, in the cycle after each accepted tick while in RUN.
REQ-027 timer_rearm SHALL also assert for one cycle on the IDLE->RUN and PAUSE->RUN transitions.
REQ-028 Digit outputs SHALL never hold non-BCD values or values above their stated ranges.
REQ-029 running SHALL be a registered decode of the state, equal to 1 exactly when the state is RUN.

Reset
REQ-030 reset_n low SHALL immediately force the following, regardless of clk:
  - state = IDLE.
  - All digits = 0.
  - tick_d = 0.
  - running, rollover and timer_rearm = 0.
REQ-031 Reset asserted mid-count SHALL discard the count, and after release the block SHALL wait in IDLE for start_stop.
REQ-032 If tick_in is already high at reset release, the first sampled cycle SHALL count as an accepted tick, which is ignored because the state is IDLE.

Verification
REQ-033 Reset, pulse start_stop, then 12 tick_in rising edges spaced 5 cycles apart -> digits 00:12, running=1, and 13 timer_rearm pulses.
REQ-034 Preload by ticking to 00:59, then one tick -> 01:00 one cycle after acceptance, with rollover=0.
REQ-035 MIN_LIMIT=2, tick to 02:59, then one tick -> 00:00 with a single-cycle rollover, and the next tick gives 00:01.
REQ-036 In RUN, hold tick_in high for 40 cycles -> exactly one increment; then pulse start_stop and 3 ticks -> count unchanged, running=0.
REQ-037 clear, start_stop and a tick all in the same RUN cycle -> IDLE, 00:00, no rollover, running=0.
REQ-038 Assert reset_n low mid-count between clock edges -> outputs zero before the next clk edge; after release, ticks give no count until start_stop.
